mux_uart: RTL and testbench

MUX_UART -- requirements
Module: mux_uart

---
 rtl/mux_uart.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_mux_uart.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_uart.sv
// mux_uart: memory-mapped 8N1 UART with a small transmit FIFO.
//
// Register window (two bytes starting at BASE_ADDR):
//   BASE_ADDR     read : STATUS  {2'b0, TXOVF, FERR, OVR, TXIDLE, TXRDY, RXRDY}
//                 write: CONTROL bit0=1 clears RXRDY, bit1=1 clears OVR/FERR/TXOVF
//   BASE_ADDR + 1 read : last received byte
//                 write: push byte into the TX FIFO (dropped with TXOVF if full)
//
// Ports:
//   clock        single clock, all state on the rising edge
//   reset        asynchronous, active-high reset
//   addressBus   CPU address; select/dataInBus decode it combinationally
//   writeEnBus   one-cycle CPU write strobe
//   dataOutBus   CPU write data
//   dataInBus    read data toward the CPU (8'h00 outside the window)
//   select       high while addressBus is inside the window
//   rx           asynchronous serial input, idle high
//   tx           serial output, idle high
//   debug_state  {tx_state, rx_state}, for observing both FSMs
//
// Reads have no side effects; there is no read strobe.
module mux_uart #(
   parameter logic [15:0] BASE_ADDR    = 16'hF200,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] addressBus,
   input  logic        writeEnBus,
   input  logic [7:0]  dataOutBus,
   output logic [7:0]  dataInBus,
   output logic        select,
   input  logic        rx,
   output logic        tx,
   output logic [3:0]  debug_state
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;

   // ---------------------------------------------------------------
   // Address decode and register access
   // ---------------------------------------------------------------
   logic is_status;
   logic is_data;
   logic wr_ctrl;
   logic wr_data;
   logic clr_rx;
   logic clr_err;

   assign is_status = (addressBus == BASE_ADDR);
   assign is_data   = (addressBus == BASE_ADDR + 16'd1);
   assign select    = is_status | is_data;
   assign wr_ctrl   = writeEnBus & is_status;
   assign wr_data   = writeEnBus & is_data;
   assign clr_rx    = wr_ctrl & dataOutBus[0];
   assign clr_err   = wr_ctrl & dataOutBus[1];

   logic       rx_rdy;
   logic       ovr;
   logic       ferr;
   logic       tx_ovf;
   logic [7:0] rx_data;
   logic       tx_idle;
   logic       tx_rdy;

   always_comb begin
      dataInBus = 8'h00;
      if (is_status)
         dataInBus = {2'b00, tx_ovf, ferr, ovr, tx_idle, tx_rdy, rx_rdy};
      else if (is_data)
         dataInBus = rx_data;
   end

   // ---------------------------------------------------------------
   // TX FIFO
   // FIFO -> shifter handshake: valid = !fifo_empty, ready = shifter in
   // IDLE or on the last clock of STOP. A transfer (tx_pop) happens on
   // any clock where both are high; the head entry stays stable while
   // valid is high and ready is low.
   // ---------------------------------------------------------------
   logic [7:0]     fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   fifo_count;
   logic           fifo_empty;
   logic           fifo_full;
   logic           tx_pop;
   logic           push_ok;
   logic           tx_ovf_set;
   logic [7:0]     fifo_head;

   uart_state_t    tx_state;
   logic [CNT_W-1:0] tx_cnt;
   logic [2:0]     tx_bit;
   logic [7:0]     tx_shift;

   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == FIFO_FULL);
   assign fifo_head  = fifo_mem[rd_ptr];
   assign tx_pop     = !fifo_empty &&
                       ((tx_state == ST_IDLE) ||
                        (tx_state == ST_STOP && tx_cnt == BIT_LAST));
   // A pop in the same clock frees a slot, so a full FIFO still accepts.
   assign push_ok    = wr_data && (!fifo_full || tx_pop);
   assign tx_ovf_set = wr_data && fifo_full && !tx_pop;
   assign tx_rdy     = !fifo_full;
   assign tx_idle    = fifo_empty && (tx_state == ST_IDLE);

   always_ff @(posedge clock) begin
      if (push_ok)
         fifo_mem[wr_ptr] <= dataOutBus;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (tx_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, tx_pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // TX FSM: 8N1, LSB first; tx is a registered output
   // ---------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_state <= ST_IDLE;
         tx       <= 1'b1;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
      end else begin
         case (tx_state)
            ST_IDLE: begin
               if (tx_pop) begin
                  tx_shift <= fifo_head;
                  tx       <= 1'b0;
                  tx_cnt   <= '0;
                  tx_state <= ST_START;
               end
            end
            ST_START: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  tx       <= tx_shift[0];
                  tx_state <= ST_DATA;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     tx       <= 1'b1;
                     tx_state <= ST_STOP;
                  end else begin
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     tx       <= tx_shift[1];
                     tx_bit   <= tx_bit + 1'b1;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt <= '0;
                  // Back-to-back frames: next start bit follows directly.
                  if (tx_pop) begin
                     tx_shift <= fifo_head;
                     tx       <= 1'b0;
                     tx_state <= ST_START;
                  end else begin
                     tx_state <= ST_IDLE;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: begin
               tx_state <= ST_IDLE;
               tx       <= 1'b1;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // RX synchronizer and FSM
   // ---------------------------------------------------------------
   logic [1:0]     rx_sync;
   logic           rx_s;
   uart_state_t    rx_state;
   logic [CNT_W-1:0] rx_cnt;
   logic [2:0]     rx_bit;
   logic [7:0]     rx_shift;
   logic           rx_wait;  // framing error seen; holding in STOP until line high
   logic           rx_good;
   logic           rx_bad;

   assign rx_s    = rx_sync[1];
   assign rx_good = (rx_state == ST_STOP) && !rx_wait && (rx_cnt == BIT_LAST) && rx_s;
   assign rx_bad  = (rx_state == ST_STOP) && !rx_wait && (rx_cnt == BIT_LAST) && !rx_s;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         rx_sync <= 2'b11;
      else
         rx_sync <= {rx_sync[0], rx};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_state <= ST_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_wait  <= 1'b0;
      end else begin
         case (rx_state)
            ST_IDLE: begin
               rx_cnt <= '0;
               if (!rx_s)
                  rx_state <= ST_START;
            end
            ST_START: begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt <= '0;
                  rx_bit <= '0;
                  // Line back high at mid start bit: treat as a glitch.
                  rx_state <= rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_s, rx_shift[7:1]};
                  if (rx_bit == 3'd7)
                     rx_state <= ST_STOP;
                  else
                     rx_bit <= rx_bit + 1'b1;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (rx_wait) begin
                  if (rx_s) begin
                     rx_wait  <= 1'b0;
                     rx_state <= ST_IDLE;
                  end
               end else if (rx_cnt == BIT_LAST) begin
                  rx_cnt <= '0;
                  if (rx_s)
                     rx_state <= ST_IDLE;
                  else
                     rx_wait <= 1'b1;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            default: rx_state <= ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Sticky flags and receive data; a set wins over a clear.
   // ---------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_rdy  <= 1'b0;
         ovr     <= 1'b0;
         ferr    <= 1'b0;
         tx_ovf  <= 1'b0;
         rx_data <= 8'h00;
      end else begin
         // A clear of RXRDY in the same clock as a good byte makes room
         // for that byte, so it is loaded and is not an overrun.
         if (rx_good && (!rx_rdy || clr_rx)) begin
            rx_data <= rx_shift;
            rx_rdy  <= 1'b1;
         end else if (clr_rx) begin
            rx_rdy <= 1'b0;
         end

         if (rx_good && rx_rdy && !clr_rx)
            ovr <= 1'b1;
         else if (clr_err)
            ovr <= 1'b0;

         if (rx_bad)
            ferr <= 1'b1;
         else if (clr_err)
            ferr <= 1'b0;

         if (tx_ovf_set)
            tx_ovf <= 1'b1;
         else if (clr_err)
            tx_ovf <= 1'b0;
      end
   end

   assign debug_state = {tx_state, rx_state};

endmodule

// File: tb/tb_mux_uart.sv
// Directed testbench for mux_uart (default parameters: window at F200,
// 16 clocks per bit, 4-entry TX FIFO).
module tb_mux_uart;

   logic        clock;
   logic        reset;
   logic [15:0] address_bus;
   logic        write_en_bus;
   logic [7:0]  data_out_bus;
   logic [7:0]  data_in_bus;
   logic        select;
   logic        rx;
   logic        tx;
   logic [3:0]  debug_state;

   int checks = 0;
   int errors = 0;

   logic [8:0] exp_q[$];   // expected {stop, byte} per TX frame
   logic [8:0] got_q[$];   // frames decoded from the tx line
   logic       mon_en = 1'b1;

   mux_uart dut (
      .clock      (clock),
      .reset      (reset),
      .addressBus (address_bus),
      .writeEnBus (write_en_bus),
      .dataOutBus (data_out_bus),
      .dataInBus  (data_in_bus),
      .select     (select),
      .rx         (rx),
      .tx         (tx),
      .debug_state(debug_state)
   );

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- tx line monitor ----------------
   // Samples mid-bit on negedges after seeing the start bit.
   initial begin : tx_monitor
      logic [7:0] b;
      logic       s;
      forever begin
         @(negedge clock);
         if (mon_en && tx === 1'b0) begin
            repeat (8) @(negedge clock);
            for (int i = 0; i < 8; i++) begin
               repeat (16) @(negedge clock);
               b[i] = tx;
            end
            repeat (16) @(negedge clock);
            s = tx;
            got_q.push_back({s, b});
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Caller is at (or just after) a negedge; write lands on the next posedge.
   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      address_bus  = a;
      data_out_bus = d;
      write_en_bus = 1'b1;
      @(negedge clock);
      write_en_bus = 1'b0;
   endtask

   task automatic send_rx_frame(input logic [7:0] d, input logic stop_bit);
      @(negedge clock);
      rx = 1'b0;
      repeat (16) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (16) @(negedge clock);
      end
      rx = stop_bit;
      repeat (16) @(negedge clock);
      rx = 1'b1;
      repeat (20) @(negedge clock);
   endtask

   task automatic wait_frames(input int n);
      for (int i = 0; i < 3000 && got_q.size() < n; i++)
         @(negedge clock);
      checks++;
      if (got_q.size() < n) begin
         errors++;
         $display("FAIL frame_count: got %0d frames, expected %0d", got_q.size(), n);
      end
   endtask

   task automatic compare_frames();
      logic [8:0] e;
      logic [8:0] g;
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL tx_frame: got %h expected %h", g, e);
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      rx = 1'b1;
      write_en_bus = 1'b0;
      data_out_bus = 8'h00;
      address_bus = 16'h0000;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (debug_state !== 4'h0) begin
         errors++; $display("FAIL reset_fsm: got %h expected 0", debug_state);
      end
   endtask

   task automatic test_decode();
      address_bus = 16'hF200; #1;
      checks++;
      if (data_in_bus !== 8'h06 || select !== 1'b1) begin
         errors++; $display("FAIL status_after_reset: got %h/%b expected 06/1", data_in_bus, select);
      end
      address_bus = 16'hF201; #1;
      checks++;
      if (data_in_bus !== 8'h00 || select !== 1'b1) begin
         errors++; $display("FAIL data_after_reset: got %h/%b expected 00/1", data_in_bus, select);
      end
      address_bus = 16'h0100; #1;
      checks++;
      if (data_in_bus !== 8'h00 || select !== 1'b0) begin
         errors++; $display("FAIL outside_0100: got %h/%b expected 00/0", data_in_bus, select);
      end
      address_bus = 16'hF1FF; #1;
      checks++;
      if (select !== 1'b0) begin errors++; $display("FAIL select_F1FF: got %b expected 0", select); end
      address_bus = 16'hF202; #1;
      checks++;
      if (data_in_bus !== 8'h00 || select !== 1'b0) begin
         errors++; $display("FAIL outside_F202: got %h/%b expected 00/0", data_in_bus, select);
      end
   endtask

   task automatic test_tx_single();
      logic [7:0] bits;
      bits = 8'hA5;
      @(negedge clock);
      got_q.delete();
      cpu_write(16'hF201, 8'hA5);
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL tx_before_start: got %b expected 1", tx); end
      @(posedge clock); #1;
      checks++;
      if (tx !== 1'b0) begin errors++; $display("FAIL tx_start_edge: got %b expected 0", tx); end
      repeat (8) @(posedge clock); #1;
      checks++;
      if (tx !== 1'b0) begin errors++; $display("FAIL tx_start_mid: got %b expected 0", tx); end
      for (int i = 0; i < 8; i++) begin
         repeat (16) @(posedge clock); #1;
         checks++;
         if (tx !== bits[i]) begin
            errors++; $display("FAIL tx_bit%0d: got %b expected %b", i, tx, bits[i]);
         end
      end
      repeat (16) @(posedge clock); #1;
      address_bus = 16'hF200; #1;
      checks++;
      if (tx !== 1'b1 || data_in_bus[2] !== 1'b0) begin
         errors++; $display("FAIL tx_stop: got tx=%b txidle=%b expected 1/0", tx, data_in_bus[2]);
      end
      repeat (10) @(posedge clock); #1;
      checks++;
      if (data_in_bus !== 8'h06) begin
         errors++; $display("FAIL tx_idle_after_frame: got %h expected 06", data_in_bus);
      end
      exp_q.push_back({1'b1, 8'hA5});
      compare_frames();
   endtask

   task automatic test_back_to_back();
      logic [7:0] vals [5];
      vals = '{8'h01, 8'h80, 8'hFF, 8'h5A, 8'hC3};
      @(negedge clock);
      got_q.delete();
      exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back({1'b1, vals[i]});
         cpu_write(16'hF201, vals[i]);
      end
      address_bus = 16'hF200; #1;
      checks++;
      if (data_in_bus !== 8'h00) begin
         errors++; $display("FAIL b2b_status_full: got %h expected 00", data_in_bus);
      end
      wait_frames(5);
      compare_frames();
      repeat (20) @(negedge clock);
      checks++;
      if (data_in_bus !== 8'h06) begin
         errors++; $display("FAIL b2b_status_end: got %h expected 06", data_in_bus);
      end
   endtask

   task automatic test_tx_overflow();
      @(negedge clock);
      got_q.delete();
      exp_q.delete();
      cpu_write(16'hF201, 8'h11);
      exp_q.push_back({1'b1, 8'h11});
      repeat (3) @(negedge clock);
      cpu_write(16'hF201, 8'h22); exp_q.push_back({1'b1, 8'h22});
      cpu_write(16'hF201, 8'h33); exp_q.push_back({1'b1, 8'h33});
      cpu_write(16'hF201, 8'h44); exp_q.push_back({1'b1, 8'h44});
      cpu_write(16'hF201, 8'h55); exp_q.push_back({1'b1, 8'h55});
      cpu_write(16'hF201, 8'h66);
      address_bus = 16'hF200; #1;
      checks++;
      if (data_in_bus !== 8'h20) begin
         errors++; $display("FAIL ovf_status: got %h expected 20", data_in_bus);
      end
      wait_frames(5);
      compare_frames();
      repeat (200) @(negedge clock);
      checks++;
      if (got_q.size() !== 0) begin
         errors++; $display("FAIL ovf_extra_frames: got %0d expected 0", got_q.size());
      end
      checks++;
      if (data_in_bus !== 8'h26) begin
         errors++; $display("FAIL ovf_sticky: got %h expected 26", data_in_bus);
      end
      cpu_write(16'hF200, 8'h02);
      address_bus = 16'hF200; #1;
      checks++;
      if (data_in_bus !== 8'h06) begin
         errors++; $display("FAIL ovf_clear: got %h expected 06", data_in_bus);
      end
   endtask

   task automatic test_rx();
      send_rx_frame(8'h3C, 1'b1);
      address_bus = 16'hF200; #1;
      checks++;
      if (data_in_bus !== 8'h07) begin errors++; $display("FAIL rx_status: got %h expected 07", data_in_bus); end
      address_bus = 16'hF201; #1;
      checks++;
      if (data_in_bus !== 8'h3C) begin errors++; $display("FAIL rx_data: got %h expected 3C", data_in_bus); end
      send_rx_frame(8'h55, 1'b1);
      address_bus = 16'hF200; #1;
      checks++;
      if (data_in_bus !== 8'h0F) begin errors++; $display("FAIL ovr_status: got %h expected 0F", data_in_bus); end
      address_bus = 16'hF201; #1;
      checks++;
      if (data_in_bus !== 8'h3C) begin errors++; $display("FAIL ovr_data: got %h expected 3C", data_in_bus); end
      @(negedge clock);
      cpu_write(16'hF200, 8'h01);
      address_bus = 16'hF200; #1;
      checks++;
      if (data_in_bus !== 8'h0E) begin errors++; $display("FAIL clr_rxrdy: got %h expected 0E", data_in_bus); end
      cpu_write(16'hF200, 8'h02);
      address_bus = 16'hF200; #1;
      checks++;
      if (data_in_bus !== 8'h06) begin errors++; $display("FAIL clr_ovr: got %h expected 06", data_in_bus); end
   endtask

   task automatic test_ferr();
      send_rx_frame(8'h81, 1'b0);
      address_bus = 16'hF200; #1;
      checks++;
      if (data_in_bus !== 8'h16) begin errors++; $display("FAIL ferr_status: got %h expected 16", data_in_bus); end
      address_bus = 16'hF201; #1;
      checks++;
      if (data_in_bus !== 8'h3C) begin errors++; $display("FAIL ferr_data: got %h expected 3C", data_in_bus); end
      @(negedge clock);
      cpu_write(16'hF200, 8'h02);
      address_bus = 16'hF200; #1;
      checks++;
      if (data_in_bus !== 8'h06) begin errors++; $display("FAIL ferr_clear: got %h expected 06", data_in_bus); end
   endtask

   task automatic test_glitch();
      @(negedge clock);
      rx = 1'b0;
      repeat (4) @(negedge clock);
      rx = 1'b1;
      repeat (30) @(negedge clock);
      address_bus = 16'hF200; #1;
      checks++;
      if (data_in_bus !== 8'h06 || debug_state !== 4'h0) begin
         errors++; $display("FAIL glitch_status: got %h/%h expected 06/0", data_in_bus, debug_state);
      end
      address_bus = 16'hF201; #1;
      checks++;
      if (data_in_bus !== 8'h3C) begin errors++; $display("FAIL glitch_data: got %h expected 3C", data_in_bus); end
   endtask

   task automatic test_write_ignored();
      @(negedge clock);
      got_q.delete();
      cpu_write(16'hF202, 8'h77);
      address_bus  = 16'hF201;
      data_out_bus = 8'h99;
      repeat (3) @(negedge clock);
      address_bus = 16'hF200; #1;
      checks++;
      if (data_in_bus !== 8'h06 || tx !== 1'b1) begin
         errors++; $display("FAIL ignored_write: got %h/%b expected 06/1", data_in_bus, tx);
      end
   endtask

   task automatic test_reset_mid_frame();
      @(negedge clock);
      mon_en = 1'b0;
      cpu_write(16'hF201, 8'h00);
      repeat (40) @(posedge clock);
      #2;
      checks++;
      if (tx !== 1'b0) begin errors++; $display("FAIL pre_reset_tx: got %b expected 0", tx); end
      reset = 1'b1;
      #1;
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx: got %b expected 1", tx); end
      address_bus = 16'hF200; #1;
      checks++;
      if (data_in_bus !== 8'h06) begin errors++; $display("FAIL reset_status: got %h expected 06", data_in_bus); end
      @(negedge clock);
      reset = 1'b0;
      repeat (200) @(negedge clock);
      checks++;
      if (tx !== 1'b1 || data_in_bus !== 8'h06) begin
         errors++; $display("FAIL post_reset: got %b/%h expected 1/06", tx, data_in_bus);
      end
      address_bus = 16'hF201; #1;
      checks++;
      if (data_in_bus !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", data_in_bus); end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_tx_single();
      test_back_to_back();
      test_tx_overflow();
      test_rx();
      test_ferr();
      test_glitch();
      test_write_ignored();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
